// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined add/subtract unit with valid/ready handshakes and a delivered-result counter
module pipe_addsub #(
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     y,
  output logic [COUNT_W-1:0] txn_count
);
  logic [STAGES-1:0]          r_v;
  logic [STAGES-1:0][WIDTH:0] r_d;
  logic [COUNT_W-1:0]         r_cnt;
  logic [STAGES-1:0]          w_en;
  logic [STAGES-1:0]          w_src_v;
  logic [STAGES-1:0][WIDTH:0] w_src_d;
  logic [WIDTH:0]             w_res;
  logic                       w_run;
  assign w_res = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    w_run   = out_ready;
    w_en    = '0;
    w_src_v = '0;
    w_src_d = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_run   = !r_v[k] || w_run;
      w_en[k] = w_run;
    end
    w_src_v[0] = in_valid;
    w_src_d[0] = w_res;
    for (int k = 1; k < STAGES; k++) begin
      w_src_v[k] = r_v[k-1];
      w_src_d[k] = r_d[k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (w_en[k]) begin
          r_v[k] <= w_src_v[k];
          r_d[k] <= w_src_d[k];
        end
      if (r_v[STAGES-1] && out_ready) r_cnt <= r_cnt + COUNT_W'(1);
    end
  end
  assign in_ready  = w_en[0];
  assign out_valid = r_v[STAGES-1];
  assign y         = r_d[STAGES-1];
  assign txn_count = r_cnt;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: scoreboard bench for pipe_addsub (WIDTH=8, STAGES=2, COUNT_W=4 to exercise counter wrap)
module tb_pipe_addsub;
  localparam int W = 8, S = 2, CW = 4;
  logic clk = 0;
  logic rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [W:0] y;
  logic [CW-1:0] txn_count;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic last_acc;
  logic [W:0] exp_q[$], got_q[$];
  int got_cyc[$];
  always #5 clk = ~clk;
  pipe_addsub #(.WIDTH(W), .STAGES(S), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .txn_count(txn_count)
  );
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] z, input logic s);
    int r;
    r = s ? int'(x) - int'(z) : int'(x) + int'(z);
    return (W+1)'(r);
  endfunction
  // Observe handshakes mid-cycle, then advance to just after the next edge.
  task automatic step();
    @(negedge clk);
    last_acc = in_valid && in_ready && !rst;
    if (rst) exp_q.delete();
    else begin
      if (last_acc) exp_q.push_back(model(a, b, sub));
      if (out_valid && out_ready) begin
        got_q.push_back(y);
        got_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; sub = 0;
    step(); step();
    rst = 0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); sub = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      step();
      n_tests++;
      if ({out_valid, y, txn_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: out_valid=%b y=%h txn=%0d, required 0/0/0", i, out_valid, y, txn_count);
      end
    end
    rst = 0; in_valid = 0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask
  task automatic test_add();
    logic [W:0] g, e;
    do_reset();
    out_ready = 1; in_valid = 1; a = 200; b = 100; sub = 0;
    step();
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency_early: out_valid=%b, required 0", out_valid);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 9'h12C) begin
      n_fail++;
      $display("FAIL add_result: out_valid=%b y=%h, required 1 12c", out_valid, y);
    end
    step();
    n_tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL add_sb_count: got %0d results, %0d expected, required 1/1", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL add_sb: y=%h, required %h", g, e);
      end
    end
    n_tests++;
    if (txn_count !== 4'd1) begin
      n_fail++;
      $display("FAIL add_txn: txn_count=%0d, required 1", txn_count);
    end
  endtask
  task automatic test_sub();
    logic [W:0] g, e;
    logic [W:0] want[2];
    want[0] = 9'h1FE; want[1] = 9'h0FF;
    do_reset();
    out_ready = 1; in_valid = 1; sub = 1; a = 5; b = 7;
    step();
    a = 255; b = 0;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL sub_sb_count: got %0d results, %0d expected, required 2/2", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 2 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (g !== e || g !== want[i]) begin
        n_fail++;
        $display("FAIL sub_result%0d: y=%h, required %h (model %h)", i, g, want[i], e);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [W:0] g, e;
    int idx = 0;
    do_reset();
    out_ready = 0; sub = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; a = W'(idx + 1); b = W'(idx + 1);
      step();
      if (last_acc) idx++;
      if (c >= 1) begin
        n_tests++;
        if (out_valid !== 1'b1 || y !== 9'd2) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: out_valid=%b y=%h, required 1 002", c, out_valid, y);
        end
      end
    end
    n_tests++;
    if (idx != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b, required 2 0", idx, in_ready);
    end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) begin
        in_valid = 1; a = W'(idx + 1); b = W'(idx + 1);
      end else in_valid = 0;
      step();
      if (last_acc) idx++;
      n_tests++;
      if (got_q.size() != c + 1) begin
        n_fail++;
        $display("FAIL bp_drain_rate c%0d: %0d results, required %0d", c, got_q.size(), c + 1);
      end
    end
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (g !== e || g !== (W+1)'(2 * (i + 1))) begin
        n_fail++;
        $display("FAIL bp_order%0d: y=%h, required %h", i, g, 2 * (i + 1));
      end
    end
    n_tests++;
    if (txn_count !== 4'd4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_txn: txn_count=%0d pending=%0d, required 4 0", txn_count, exp_q.size());
    end
  endtask
  task automatic test_back_to_back();
    logic [W:0] g, e;
    int stalls = 0;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1; sub = 1'($urandom); a = W'($urandom); b = W'($urandom);
      step();
      if (!last_acc) stalls++;
    end
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL b2b_input_bubbles: %0d refused beats, required 0", stalls);
    end
    n_tests++;
    if (got_q.size() != 17 || got_cyc.size() != 17 || got_cyc[16] - got_cyc[0] != 16) begin
      n_fail++;
      $display("FAIL b2b_output_bubbles: %0d results, required 17 in 17 consecutive cycles", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_sb: y=%h, required %h", g, e);
      end
    end
    n_tests++;
    if (txn_count !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_txn_wrap: txn_count=%0d, required 1", txn_count);
    end
  endtask
  task automatic test_reset_midflight();
    logic [W:0] g, e;
    do_reset();
    out_ready = 0; in_valid = 1; sub = 0; a = 9; b = 9;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    rst = 1; out_ready = 1;
    step();
    rst = 0; in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b0 || y !== '0 || txn_count !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b y=%h txn=%0d, required 0 000 0", out_valid, y, txn_count);
    end
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_stale: %0d stale results, required 0", got_q.size());
    end
    in_valid = 1; sub = 1; a = 10; b = 3;
    step();
    in_valid = 0;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 9'd7) begin
      n_fail++;
      $display("FAIL mid_after: out_valid=%b y=%h, required 1 007", out_valid, y);
    end
    step();
    n_tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL mid_sb_count: got %0d results, %0d expected, required 1/1", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL mid_sb: y=%h, required %h", g, e);
      end
    end
  endtask
  initial begin
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; sub = 0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
